// File: rtl/me_sched_pkg.sv
// Shared definitions for the me core scheduler: FSM states, op codes, error codes, tag width.
package me_sched_pkg;

  localparam int unsigned TAG_W = 4;

  localparam logic [1:0] OP_MM = 2'b01;
  localparam logic [1:0] OP_ME = 2'b10;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_TAG = 2'b10;
  localparam logic [1:0] ERR_OP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_GO,
    ST_PRE_WAIT,
    ST_ME_GO,
    ST_ME_WAIT,
    ST_MM_GO,
    ST_MM_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/me_sched_rr_arb.sv
// Round-robin picker: one-hot grant of the first requester after last_owner, wrapping.
module me_sched_rr_arb #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [N_REQ-1:0]         pick_c,
  output logic [$clog2(N_REQ)-1:0] pick_idx_c,
  output logic                     any_c
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_c     = '0;
    pick_idx_c = '0;
    any_c      = |req;
    // first hit scanning upward from last_owner+1 wins
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_owner) + k) % N_REQ;
      if ((pick_c == '0) && req[idx]) begin
        pick_c[idx] = 1'b1;
        pick_idx_c  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/me_sched.sv
// Grants one shared me core to N_REQ requesters, sequences pre_me/me or one_mm phases,
// checks returned job tags and enforces a per-phase watchdog.
module me_sched
  import me_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned TMO_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [TMO_W-1:0]         tmo_limit,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     en_pre_me,
  output logic                     en_me,
  output logic                     en_one_mm,
  output logic [TAG_W-1:0]         num,
  input  logic                     core_done,
  input  logic [TAG_W-1:0]         core_num_out,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [1:0]               rsp_err,
  output logic                     busy
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_d;
  logic [N_REQ-1:0]   pick_c;
  logic [SEL_W-1:0]   sel_d, pick_idx_c, last_q, last_d;
  logic [TAG_W-1:0]   num_d;
  logic [1:0]         seq_q, seq_d, err_d, op_c;
  logic [TMO_W-1:0]   wdog_q, wdog_d, wdog_inc_c;
  logic               any_c, tag_ok_c, tmo_hit_c;

  me_sched_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req        (req),
    .last_owner (last_q),
    .pick_c     (pick_c),
    .pick_idx_c (pick_idx_c),
    .any_c      (any_c)
  );

  assign op_c       = req_op[2*int'(pick_idx_c) +: 2];
  assign tag_ok_c   = (core_num_out == num);
  assign wdog_inc_c = wdog_q + TMO_W'(1);
  assign tmo_hit_c  = (tmo_limit != '0) && (wdog_inc_c == tmo_limit);

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    sel_d   = sel;
    num_d   = num;
    seq_d   = seq_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = ERR_OK;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          grant_d = pick_c;
          sel_d   = pick_idx_c;
          num_d   = {seq_q, 2'(pick_idx_c)};
          case (op_c)
            OP_ME:   state_d = ST_PRE_GO;
            OP_MM:   state_d = ST_MM_GO;
            default: begin
              state_d = ST_RESP;
              err_d   = ERR_OP;
            end
          endcase
        end
      end
      ST_PRE_GO: begin
        wdog_d  = '0;
        state_d = ST_PRE_WAIT;
      end
      ST_ME_GO: begin
        wdog_d  = '0;
        state_d = ST_ME_WAIT;
      end
      ST_MM_GO: begin
        wdog_d  = '0;
        state_d = ST_MM_WAIT;
      end
      ST_PRE_WAIT, ST_ME_WAIT, ST_MM_WAIT: begin
        wdog_d = wdog_inc_c;
        // a completion in the same cycle as the timeout takes priority
        if (core_done) begin
          if (!tag_ok_c) begin
            state_d = ST_RESP;
            err_d   = ERR_TAG;
          end else if (state_q == ST_PRE_WAIT) begin
            state_d = ST_ME_GO;
          end else begin
            state_d = ST_RESP;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_RESP;
          err_d   = ERR_TMO;
        end
      end
      ST_RESP: begin
        seq_d   = seq_q + 2'd1;
        last_d  = sel;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant     <= '0;
      sel       <= '0;
      num       <= '0;
      seq_q     <= '0;
      last_q    <= SEL_W'(N_REQ - 1);
      wdog_q    <= '0;
      en_pre_me <= 1'b0;
      en_me     <= 1'b0;
      en_one_mm <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      sel       <= sel_d;
      num       <= num_d;
      seq_q     <= seq_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      en_pre_me <= (state_d == ST_PRE_GO);
      en_me     <= (state_d == ST_ME_GO);
      en_one_mm <= (state_d == ST_MM_GO);
      rsp_valid <= (state_d == ST_RESP) ? grant_d : '0;
      rsp_err   <= err_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_me_sched.sv
// Directed bench for me_sched: a job-level model plans expected per-cycle outputs, checked every cycle.
module tb_me_sched;

  localparam int NCYC = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] req_op;
  logic [15:0] tmo_limit;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       en_pre_me, en_me, en_one_mm;
  logic [3:0] num;
  logic       core_done;
  logic [3:0] core_num_out;
  logic [3:0] rsp_valid;
  logic [1:0] rsp_err;
  logic       busy;

  me_sched #(.N_REQ(4), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .tmo_limit(tmo_limit),
    .grant(grant), .sel(sel), .en_pre_me(en_pre_me), .en_me(en_me), .en_one_mm(en_one_mm),
    .num(num), .core_done(core_done), .core_num_out(core_num_out),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit run     = 1'b0;
  int seq_m   = 0;
  int last_m  = 3;

  bit [3:0] exp_grant [NCYC];
  bit [1:0] exp_sel   [NCYC];
  bit [2:0] exp_en    [NCYC];
  bit [3:0] exp_rsp   [NCYC];
  bit [1:0] exp_err   [NCYC];
  bit       exp_busy  [NCYC];
  bit [3:0] exp_num   [NCYC];
  bit       num_chk   [NCYC];

  int n_mm = 0, n_pre = 0, n_me = 0, n_rsp = 0;
  int mm_cyc = 0, rsp_cyc = 0;
  logic [3:0] mm_num, pre_num, me_num, rsp_val;
  logic [1:0] rsp_e;
  logic prev_g = 1'b0;
  int grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the planned expectations
  always @(negedge clk) begin
    if (run && cyc < NCYC) begin
      chk("grant", 32'(grant), 32'(exp_grant[cyc]));
      chk("en", 32'({en_pre_me, en_me, en_one_mm}), 32'(exp_en[cyc]));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      if (exp_rsp[cyc] != 4'd0) chk("rsp_err", 32'(rsp_err), 32'(exp_err[cyc]));
      if (exp_grant[cyc] != 4'd0) chk("sel", 32'(sel), 32'(exp_sel[cyc]));
      if (num_chk[cyc]) chk("num", 32'(num), 32'(exp_num[cyc]));
    end
  end

  // Event log feeding the literal pins
  always @(negedge clk) begin
    if (en_one_mm) begin n_mm <= n_mm + 1; mm_cyc <= cyc; mm_num <= num; end
    if (en_pre_me) begin n_pre <= n_pre + 1; pre_num <= num; end
    if (en_me)     begin n_me <= n_me + 1; me_num <= num; end
    if (|rsp_valid) begin n_rsp <= n_rsp + 1; rsp_cyc <= cyc; rsp_val <= rsp_valid; rsp_e <= rsp_err; end
    if ((|grant) && !prev_g) begin
      for (int i = 0; i < 4; i++) if (grant[i]) grant_log.push_back(i);
    end
    prev_g <= |grant;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seq_m = 0;
    last_m = 3;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Plan one job from the current req vector (cycle cyc is the IDLE sample cycle), then drive it.
  // k1/k2: 0-based wait cycle of each phase's core_done (-1 none); spur: offset of an ignored
  // wrong-tag core_done (-1 none); abort_at: offset at which reset hits (-1 none).
  task automatic job(input int k1, input int k2, input int lim, input bit bad, input int spur,
                     input int abort_at, input bit drop, input bit keep);
    int t, o, g, r, nph, stop;
    int k[2], gs[2], ends[2], dcs[2];
    logic [1:0] op, err;
    logic [3:0] tag, oh;
    logic [2:0] en_bit[2];
    t = cyc; o = -1; r = -1; err = 2'b00; nph = 0;
    k[0] = k1; k[1] = k2;
    gs[0] = -1; gs[1] = -1; ends[0] = -1; ends[1] = -1; dcs[0] = -1; dcs[1] = -1;
    en_bit[0] = 3'b000; en_bit[1] = 3'b000;
    for (int i = 1; i <= 4; i++) if (o < 0 && req[(last_m + i) % 4]) o = (last_m + i) % 4;
    if (o < 0) return;
    op  = req_op[2*o +: 2];
    tag = {2'(seq_m), 2'(o)};
    oh  = 4'(1 << o);
    tmo_limit = 16'(lim);
    if (op == 2'b10) begin nph = 2; en_bit[0] = 3'b100; en_bit[1] = 3'b010; end
    else if (op == 2'b01) begin nph = 1; en_bit[0] = 3'b001; end
    g = t + 1;
    if (nph == 0) begin r = t + 1; err = 2'b11; end
    for (int p = 0; p < nph; p++) begin
      if (r < 0) begin
        gs[p] = g;
        if (k[p] >= 0 && (lim == 0 || k[p] + 1 <= lim)) begin
          dcs[p] = g + 1 + k[p];
          ends[p] = dcs[p];
          if (bad) begin r = dcs[p] + 1; err = 2'b10; end
          else if (p == nph - 1) begin r = dcs[p] + 1; err = 2'b00; end
          else g = dcs[p] + 1;
        end else begin
          ends[p] = g + lim;
          r = g + lim + 1;
          err = 2'b01;
        end
      end
    end
    stop = (abort_at >= 0) ? t + abort_at : r + 1;
    for (int c = t + 1; c <= r; c++) begin
      if (c < stop) begin exp_grant[c] = oh; exp_sel[c] = 2'(o); exp_busy[c] = 1'b1; end
    end
    for (int p = 0; p < 2; p++) begin
      if (gs[p] >= 0 && gs[p] < stop) exp_en[gs[p]] = en_bit[p];
      if (gs[p] >= 0) begin
        for (int c = gs[p]; c <= ends[p]; c++) if (c < stop) begin exp_num[c] = tag; num_chk[c] = 1'b1; end
      end
    end
    if (r < stop) begin exp_rsp[r] = oh; exp_err[r] = err; end
    for (int c = t; c < stop; c++) begin
      core_done = (c == dcs[0]) || (c == dcs[1]) || (spur >= 0 && c == t + spur);
      core_num_out = ((c == dcs[0] || c == dcs[1]) && !bad) ? tag : ~tag;
      if (drop && c == t + 2) req[o] = 1'b0;
      step();
    end
    core_done = 1'b0;
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      req[o] = 1'b0;
      step(); step();
      rst_n = 1'b1;
      seq_m = 0;
      last_m = 3;
      step();
    end else begin
      if (!keep) req[o] = 1'b0;
      seq_m = (seq_m + 1) % 4;
      last_m = o;
    end
  endtask

  initial begin
    int t, a, b, c;
    rst_n = 1'b0; req = '0; req_op = '0; tmo_limit = '0; core_done = 1'b0; core_num_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_en", 32'({en_pre_me, en_me, en_one_mm}), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0; run = 1'b1;

    // single one_mm, done at wait cycle 5
    step();
    req = 4'b0001; req_op = 8'h01; t = cyc; a = n_mm;
    job(5, -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t1_latency", 32'(rsp_cyc - t), 32'd8);
    chk("t1_rsp", 32'(rsp_val), 32'h1);
    chk("t1_mm_cnt", 32'(n_mm - a), 32'd1);

    // full exponentiation on requester 1
    do_reset();
    req = 4'b0010; req_op = 8'b0000_1000; a = n_pre; b = n_me; c = n_rsp;
    job(2, 4, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t2_pre_num", 32'(pre_num), 32'h1);
    chk("t2_me_num", 32'(me_num), 32'h1);
    chk("t2_phases", 32'({n_pre - a, n_me - b}), 32'({32'd1, 32'd1}));
    chk("t2_rsp", 32'({n_rsp - c, 32'(rsp_val)}), 32'({32'd1, 32'h2}));

    // all four requesting one_mm: round-robin order
    do_reset();
    grant_log.delete();
    req = 4'b1111; req_op = 8'b01_01_01_01;
    for (int j = 0; j < 5; j++) job(1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b1);
    req = '0;
    step();
    chk("t3_grants", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5)
      chk("t3_order", {8'(grant_log[0]), 6'(grant_log[1]), 6'(grant_log[2]), 6'(grant_log[3]), 6'(grant_log[4])},
          {8'd0, 6'd1, 6'd2, 6'd3, 6'd0});

    // watchdog: timeout, disabled watchdog, completion on the timeout cycle
    req = 4'b0100; req_op = 8'b0001_0000;
    job(-1, -1, 8, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t4_tmo_lat", 32'(rsp_cyc - mm_cyc), 32'd9);
    chk("t4_tmo_err", 32'(rsp_e), 32'd1);
    step();
    req = 4'b0100; t = cyc;
    job(40, -1, 0, 1'b0, 1, -1, 1'b0, 1'b0);
    chk("t4_notmo_lat", 32'(rsp_cyc - t), 32'd43);
    chk("t4_notmo_err", 32'(rsp_e), 32'd0);
    req = 4'b0100;
    job(7, -1, 8, 1'b0, 0, -1, 1'b1, 1'b0);
    chk("t4_tie_err", 32'(rsp_e), 32'd0);

    // tag mismatch on pre_me, then illegal op
    do_reset();
    req = 4'b0001; req_op = 8'b0000_0010; b = n_me;
    job(3, 3, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    chk("t5_tag_err", 32'(rsp_e), 32'd2);
    chk("t5_no_me", 32'(n_me - b), 32'd0);
    req = 4'b1000; req_op = 8'b1100_0000; a = n_mm + n_pre + n_me;
    job(-1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t5_op_err", 32'(rsp_e), 32'd3);
    chk("t5_no_en", 32'(n_mm + n_pre + n_me - a), 32'd0);
    step();
    req = 4'b0001; req_op = 8'b0000_0000;
    job(-1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t5_op00_err", 32'(rsp_e), 32'd3);

    // reset during ME_WAIT abandons the job; next tag restarts at seq 0
    step();
    req = 4'b0001; req_op = 8'b0000_0010; c = n_rsp;
    job(1, -1, 30, 1'b0, -1, 7, 1'b0, 1'b0);
    chk("t6_no_rsp", 32'(n_rsp - c), 32'd0);
    req = 4'b0001; req_op = 8'b0000_0001;
    job(2, -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    chk("t6_num", 32'(mm_num), 32'h0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/me_sched.md
ME_SCHED -- requirements
Module: me_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one me core.
REQ-002 Parameter TMO_W, default 16, width of the per-phase watchdog counter.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  N_REQ  per-requester request level, held until its rsp_valid.
REQ-006 req_op  input  2*N_REQ  per-requester op: 01 one_mm, 10 full exponentiation (pre_me then me), 00/11 illegal.
REQ-007 tmo_limit  input  TMO_W  max cycles to wait for core_done per phase; 0 disables watchdog.
REQ-008 grant  output  N_REQ  one-hot owner of the core, held for the whole job.
REQ-009 sel  output  log2(N_REQ)  binary index of grant, drives operand muxes.
REQ-010 en_pre_me, en_me, en_one_mm  output  1 each  single-cycle start pulses to core.
REQ-011 num  output  4  job tag {seq[1:0], sel[1:0]}, stable from start pulse until phase done.
REQ-012 core_done  input  1  core phase-complete pulse.
REQ-013 core_num_out  input  4  tag returned with core_done.
REQ-014 rsp_valid  output  N_REQ  one-cycle completion pulse to owner.
REQ-015 rsp_err  output  2  00 ok, 01 timeout, 10 tag mismatch, 11 illegal op; valid with rsp_valid.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 States: IDLE, PRE_GO, PRE_WAIT, ME_GO, ME_WAIT, MM_GO, MM_WAIT, RESP.
REQ-018 IDLE: if any req, round-robin pick starting at (last_owner+1) mod N_REQ; latch grant, sel, op; advance next cycle.
REQ-019 Op 10 -> PRE_GO; op 01 -> MM_GO; illegal -> RESP with rsp_err=11, no core pulse.
REQ-020 *_GO states assert the matching en_* for exactly one cycle, clear watchdog, then go to matching *_WAIT.
REQ-021 PRE_WAIT on core_done with tag match -> ME_GO; ME_WAIT/MM_WAIT on core_done with tag match -> RESP err=00.
REQ-022 core_done with core_num_out != num -> RESP err=10; remaining phases skipped.
REQ-023 Watchdog increments each *_WAIT cycle; reaching tmo_limit (nonzero) -> RESP err=01; core_done in the same cycle wins.
REQ-024 core_done in IDLE or *_GO is ignored.
REQ-025 RESP: rsp_valid[sel]=1 one cycle, seq increments mod 4, last_owner=sel, grant cleared, -> IDLE.
REQ-026 Latency, one_mm with core_done at wait cycle k: grant at T+1, en_one_mm at T+1, rsp_valid at T+k+3 (T = req sample cycle).
REQ-027 A requester deasserting req mid-job does not abort; rsp still issued.
REQ-028 Minimum one IDLE cycle between jobs; no back-to-back grant without IDLE.
REQ-029 At most one en_* high in any cycle; grant popcount <=1 always.

Reset
REQ-030 Asynchronous rst_n low: state=IDLE, grant=0, sel=0, en_*=0, num=0, rsp_valid=0, rsp_err=0, busy=0, seq=0, last_owner=N_REQ-1, watchdog=0.
REQ-031 Reset mid-job abandons job with no rsp_valid; core is re-armed by the next en_* pulse.

Structure
REQ-032 Shared package holds state enum, op codes (OP_MM=01, OP_ME=10), error codes, TAG_W=4.
REQ-033 One sub-module rr_arb (N_REQ, combinational one-hot pick from req and last_owner) is natural; FSM, watchdog, tag logic stay in me_sched.

Verification
REQ-034 req=0001, op0=01, core_done with tag 0x0 after 5 cycles -> en_one_mm once, rsp_valid=0001, rsp_err=00, seq->1.
REQ-035 req=0010, op1=10, two matching core_done -> en_pre_me then en_me pulses, num=0x1 both phases, single rsp_valid=0010 err=00.
REQ-036 req=1111 all op 01, after reset -> grants in order 0,1,2,3,0 with one IDLE gap each.
REQ-037 tmo_limit=8, no core_done -> rsp_err=01 exactly 8 wait cycles after start pulse; tmo_limit=0 never times out.
REQ-038 core_num_out=0xF against num=0x0 -> rsp_err=10, no en_me pulse; op=11 -> rsp_err=11, no en_* pulse.
REQ-039 rst_n low during ME_WAIT -> all outputs zero immediately, no rsp_valid, next job tag seq restarts at 0.
